// File: rtl/fifo_pack_pkg.sv
// Shared widths, pad value and state encoding for the FIFO byte packer.
// The state is simply {out_valid, lo_valid}; the enum gives those pairs readable names.
package fifo_pack_pkg;

  localparam int FIFO_WIDTH_DEF = 8;
  localparam int CNT_WIDTH_DEF  = 16;

  localparam logic [7:0] PAD_BYTE = 8'h00;

  typedef enum logic [1:0] {
    S_IDLE      = 2'b00,
    S_HALF      = 2'b01,
    S_WORD      = 2'b10,
    S_WORD_HALF = 2'b11
  } pack_state_e;

  // Bytes held or in flight: the low byte, a full word counted as two, and a pending read.
  function automatic logic [2:0] occupancy(input logic loValid, input logic outValid,
                                           input logic rdPend);
    return {2'b00, loValid} + {1'b0, outValid, 1'b0} + {2'b00, rdPend};
  endfunction

endpackage

// File: rtl/pack_out_reg.sv
// Output word register with valid/ready handshake; the word and pad flag hold while stalled.
module pack_out_reg #(
  parameter int DataWidth = 16
) (
  input  logic                 clk,
  input  logic                 rst_,
  input  logic                 load_i,
  input  logic [DataWidth-1:0] data_i,
  input  logic                 pad_i,
  input  logic                 ready_i,
  output logic                 valid_o,
  output logic [DataWidth-1:0] data_o,
  output logic                 pad_o,
  output logic                 xfer_o
);

  logic                 valid_q, valid_d;
  logic [DataWidth-1:0] data_q, data_d;
  logic                 pad_q, pad_d;

  assign xfer_o  = valid_q && ready_i;
  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign pad_o   = pad_q;

  // A load wins over a drain so a new word can replace the one leaving on the same edge.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    pad_d   = pad_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      pad_d   = pad_i;
    end else if (xfer_o) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      pad_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      pad_q   <= pad_d;
    end
  end

endmodule

// File: rtl/fifo_byte_packer.sv
// Pops bytes from an upstream FIFO and packs pairs into 2-byte words with valid/ready output,
// padding a lone byte on flush and counting accepted words.
module fifo_byte_packer
  import fifo_pack_pkg::*;
#(
  parameter int fifo_width = FIFO_WIDTH_DEF,
  parameter int cnt_width  = CNT_WIDTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst_,
  input  logic                    fifo_empty,
  input  logic [fifo_width-1:0]   fifo_data_out,
  output logic                    fifo_read,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*fifo_width-1:0] out_data,
  output logic                    out_pad,
  output logic [cnt_width-1:0]    words_sent
);

  logic                    rdPend_q;
  logic                    loValid_q, loValid_d;
  logic [fifo_width-1:0]   loByte_q, loByte_d;
  logic [cnt_width-1:0]    wordsSent_q, wordsSent_d;

  logic                    wordLoad;
  logic [2*fifo_width-1:0] wordData;
  logic                    wordPad;
  logic                    xfer;
  logic                    outFree;
  logic [2:0]              occ;
  pack_state_e             packState;

  assign packState = pack_state_e'({out_valid, loValid_q});
  assign occ       = occupancy(loValid_q, out_valid, rdPend_q);
  assign outFree   = !out_valid || out_ready;

  // At most three bytes may be held or in flight; a fourth is allowed only while a word drains.
  assign fifo_read = rst_ && !fifo_empty && !flush &&
                     ((occ <= 3'd2) || ((occ == 3'd3) && xfer));

  always_comb begin
    loValid_d = loValid_q;
    loByte_d  = loByte_q;
    wordLoad  = 1'b0;
    wordData  = '0;
    wordPad   = 1'b0;
    case (packState)
      S_IDLE, S_WORD: begin
        if (rdPend_q) begin
          loByte_d  = fifo_data_out;
          loValid_d = 1'b1;
        end
      end
      S_HALF, S_WORD_HALF: begin
        if (rdPend_q) begin
          wordLoad  = 1'b1;
          wordData  = {fifo_data_out, loByte_q};
          loValid_d = 1'b0;
        end else if (flush && outFree) begin
          wordLoad  = 1'b1;
          wordData  = {fifo_width'(PAD_BYTE), loByte_q};
          wordPad   = 1'b1;
          loValid_d = 1'b0;
        end
      end
      default: begin
        loValid_d = loValid_q;
      end
    endcase
  end

  always_comb begin
    wordsSent_d = wordsSent_q;
    if (xfer && !(&wordsSent_q)) begin
      wordsSent_d = wordsSent_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      rdPend_q    <= 1'b0;
      loValid_q   <= 1'b0;
      loByte_q    <= '0;
      wordsSent_q <= '0;
    end else begin
      rdPend_q    <= fifo_read;
      loValid_q   <= loValid_d;
      loByte_q    <= loByte_d;
      wordsSent_q <= wordsSent_d;
    end
  end

  assign words_sent = wordsSent_q;

  pack_out_reg #(
    .DataWidth(2*fifo_width)
  ) u_out_reg (
    .clk    (clk),
    .rst_   (rst_),
    .load_i (wordLoad),
    .data_i (wordData),
    .pad_i  (wordPad),
    .ready_i(out_ready),
    .valid_o(out_valid),
    .data_o (out_data),
    .pad_o  (out_pad),
    .xfer_o (xfer)
  );

endmodule

// File: tb/tb_fifo_byte_packer.sv
// Self-checking bench: behavioural FIFO feeding the packer, expected words built from byte pairs.
module tb_fifo_byte_packer;

  logic        clk = 1'b0;
  logic        rst_;
  logic        fifo_empty;
  logic [7:0]  fifo_data_out = 8'h00;
  logic        fifo_read;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_pad;
  logic [15:0] words_sent;

  logic        satRead;
  logic        satValid;
  logic [15:0] satData;
  logic        satPad;
  logic [1:0]  satWords;

  int passCnt = 0;
  int checkCnt = 0;
  int expSent = 0;

  always #5 clk = ~clk;

  fifo_byte_packer dut (
    .clk(clk), .rst_(rst_), .fifo_empty(fifo_empty), .fifo_data_out(fifo_data_out),
    .fifo_read(fifo_read), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_pad(out_pad), .words_sent(words_sent)
  );

  // Narrow counter copy sharing every input, so saturation is reached in a few words.
  fifo_byte_packer #(.fifo_width(8), .cnt_width(2)) dutSat (
    .clk(clk), .rst_(rst_), .fifo_empty(fifo_empty), .fifo_data_out(fifo_data_out),
    .fifo_read(satRead), .flush(flush), .out_valid(satValid), .out_ready(out_ready),
    .out_data(satData), .out_pad(satPad), .words_sent(satWords)
  );

  logic [7:0] fifoMem [256];
  int wrPtr = 0;
  int rdPtr = 0;
  assign fifo_empty = (wrPtr == rdPtr);

  always @(posedge clk) begin
    if (fifo_read && !fifo_empty) begin
      fifo_data_out <= fifoMem[rdPtr % 256];
      rdPtr <= rdPtr + 1;
    end
  end

  logic [16:0] gotQ [$];
  int readCnt = 0;
  int emptyReadViol = 0;

  always @(negedge clk) begin
    if (fifo_read) begin
      readCnt++;
      if (fifo_empty) emptyReadViol++;
    end
    if (rst_ && out_valid && out_ready) gotQ.push_back({out_pad, out_data});
  end

  assert property (@(posedge clk) disable iff (!rst_) !(fifo_read && fifo_empty))
    else $error("[TB] FAIL sva_read_on_empty fifo_read=1 while fifo_empty=1");

  task automatic pushByte(input logic [7:0] v);
    fifoMem[wrPtr % 256] = v;
    wrPtr = wrPtr + 1;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic test_reset;
    rst_ = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    pushByte(8'h11); pushByte(8'h22); pushByte(8'h33); pushByte(8'h44);
    tick(3);
    checkCnt++;
    if (fifo_read !== 1'b0) $display("[TB] FAIL reset_fifo_read got=%b exp=0", fifo_read);
    else passCnt++;
    checkCnt++;
    if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid got=%b exp=0", out_valid);
    else passCnt++;
    checkCnt++;
    if (out_pad !== 1'b0) $display("[TB] FAIL reset_out_pad got=%b exp=0", out_pad);
    else passCnt++;
    checkCnt++;
    if (out_data !== 16'h0000) $display("[TB] FAIL reset_out_data got=%h exp=0000", out_data);
    else passCnt++;
    checkCnt++;
    if (words_sent !== 16'h0000) $display("[TB] FAIL reset_words_sent got=%0d exp=0", words_sent);
    else passCnt++;
  endtask

  task automatic test_basic;
    int rdIdx = 0;
    int secondRd = -100;
    int firstValid = -1;
    gotQ.delete();
    rst_ = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (fifo_read) begin
        rdIdx++;
        if (rdIdx == 2) secondRd = i;
      end
      if (out_valid && firstValid < 0) firstValid = i;
    end
    tick(1);
    expSent += 2;
    checkCnt++;
    if (firstValid - secondRd !== 2)
      $display("[TB] FAIL basic_latency got=%0d exp=2", firstValid - secondRd);
    else passCnt++;
    checkCnt++;
    if (gotQ.size() !== 2) $display("[TB] FAIL basic_word_count got=%0d exp=2", gotQ.size());
    else passCnt++;
    checkCnt++;
    if (gotQ.size() < 1 || gotQ[0] !== {1'b0, 16'h2211})
      $display("[TB] FAIL basic_word0 got=%h exp=%h", (gotQ.size() > 0) ? gotQ[0] : 17'h0, {1'b0, 16'h2211});
    else passCnt++;
    checkCnt++;
    if (gotQ.size() < 2 || gotQ[1] !== {1'b0, 16'h4433})
      $display("[TB] FAIL basic_word1 got=%h exp=%h", (gotQ.size() > 1) ? gotQ[1] : 17'h0, {1'b0, 16'h4433});
    else passCnt++;
    checkCnt++;
    if (words_sent !== 16'(expSent)) $display("[TB] FAIL basic_words_sent got=%0d exp=%0d", words_sent, expSent);
    else passCnt++;
  endtask

  task automatic test_back_to_back;
    logic [7:0] b [16];
    int firstRd = -1;
    int lastRd = -1;
    int reads = 0;
    gotQ.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      b[i] = 8'($urandom);
      pushByte(b[i]);
    end
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (fifo_read) begin
        reads++;
        if (firstRd < 0) firstRd = i;
        lastRd = i;
      end
    end
    tick(1);
    expSent += 8;
    checkCnt++;
    if (reads !== 16 || lastRd - firstRd !== 15)
      $display("[TB] FAIL b2b_throughput reads=%0d span=%0d exp reads=16 span=15", reads, lastRd - firstRd);
    else passCnt++;
    checkCnt++;
    if (gotQ.size() !== 8) $display("[TB] FAIL b2b_word_count got=%0d exp=8", gotQ.size());
    else passCnt++;
    for (int k = 0; k < 8 && k < gotQ.size(); k++) begin
      checkCnt++;
      if (gotQ[k] !== {1'b0, b[2*k+1], b[2*k]})
        $display("[TB] FAIL b2b_word%0d got=%h exp=%h", k, gotQ[k], {1'b0, b[2*k+1], b[2*k]});
      else passCnt++;
    end
    checkCnt++;
    if (words_sent !== 16'(expSent)) $display("[TB] FAIL b2b_words_sent got=%0d exp=%0d", words_sent, expSent);
    else passCnt++;
  endtask

  task automatic test_backpressure;
    logic [7:0] b [6];
    int readBase;
    int holdErr = 0;
    gotQ.delete();
    out_ready = 1'b0;
    readBase = readCnt;
    for (int i = 0; i < 6; i++) begin
      b[i] = 8'($urandom);
      pushByte(b[i]);
    end
    tick(10);
    checkCnt++;
    if (readCnt - readBase !== 3) $display("[TB] FAIL bp_read_stop got=%0d exp=3", readCnt - readBase);
    else passCnt++;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_data !== {b[1], b[0]} || out_pad !== 1'b0 || fifo_read !== 1'b0)
        holdErr++;
    end
    tick(1);
    checkCnt++;
    if (holdErr !== 0) $display("[TB] FAIL bp_hold got=%h errors=%0d exp=%h", out_data, holdErr, {b[1], b[0]});
    else passCnt++;
    out_ready = 1'b1;
    tick(10);
    expSent += 3;
    checkCnt++;
    if (gotQ.size() !== 3) $display("[TB] FAIL bp_word_count got=%0d exp=3", gotQ.size());
    else passCnt++;
    for (int k = 0; k < 3 && k < gotQ.size(); k++) begin
      checkCnt++;
      if (gotQ[k] !== {1'b0, b[2*k+1], b[2*k]})
        $display("[TB] FAIL bp_word%0d got=%h exp=%h", k, gotQ[k], {1'b0, b[2*k+1], b[2*k]});
      else passCnt++;
    end
  endtask

  task automatic test_flush;
    logic [7:0] b [3];
    gotQ.delete();
    out_ready = 1'b1;
    pushByte(8'h55);
    tick(6);
    checkCnt++;
    if (gotQ.size() !== 0) $display("[TB] FAIL flush_odd_held got=%0d words exp=0", gotQ.size());
    else passCnt++;
    flush = 1'b1;
    tick(3);
    flush = 1'b0;
    tick(2);
    expSent += 1;
    checkCnt++;
    if (gotQ.size() !== 1 || gotQ[0] !== {1'b1, 16'h0055})
      $display("[TB] FAIL flush_pad_word got=%h count=%0d exp=%h", (gotQ.size() > 0) ? gotQ[0] : 17'h0, gotQ.size(), {1'b1, 16'h0055});
    else passCnt++;
    flush = 1'b1;
    tick(5);
    flush = 1'b0;
    tick(2);
    checkCnt++;
    if (gotQ.size() !== 1) $display("[TB] FAIL flush_no_byte got=%0d words exp=1", gotQ.size());
    else passCnt++;

    gotQ.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      b[i] = 8'($urandom);
      pushByte(b[i]);
    end
    tick(8);
    flush = 1'b1;
    tick(4);
    checkCnt++;
    if (out_valid !== 1'b1 || out_data !== {b[1], b[0]} || out_pad !== 1'b0)
      $display("[TB] FAIL flush_blocked got=%h pad=%b exp=%h pad=0", out_data, out_pad, {b[1], b[0]});
    else passCnt++;
    out_ready = 1'b1;
    tick(3);
    flush = 1'b0;
    tick(2);
    expSent += 2;
    checkCnt++;
    if (gotQ.size() !== 2 || gotQ[0] !== {1'b0, b[1], b[0]} || gotQ[1] !== {1'b1, 8'h00, b[2]})
      $display("[TB] FAIL flush_deferred count=%0d got0=%h got1=%h exp %h %h", gotQ.size(),
               (gotQ.size() > 0) ? gotQ[0] : 17'h0, (gotQ.size() > 1) ? gotQ[1] : 17'h0,
               {1'b0, b[1], b[0]}, {1'b1, 8'h00, b[2]});
    else passCnt++;
  endtask

  task automatic test_random;
    logic [7:0] b [40];
    int pushed = 0;
    int holdErr = 0;
    int budget = 0;
    logic prevStall = 1'b0;
    logic [16:0] prevWord = '0;
    gotQ.delete();
    for (int cyc = 0; cyc < 400 && pushed < 40; cyc++) begin
      @(posedge clk);
      #2;
      if ($urandom_range(0, 2) != 0) begin
        b[pushed] = 8'($urandom);
        pushByte(b[pushed]);
        pushed++;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (prevStall && (out_valid !== 1'b1 || {out_pad, out_data} !== prevWord)) holdErr++;
      prevStall = out_valid && !out_ready;
      prevWord = {out_pad, out_data};
    end
    tick(1);
    out_ready = 1'b1;
    while (gotQ.size() < pushed / 2 && budget < 100) begin
      tick(1);
      budget++;
    end
    tick(2);
    expSent += pushed / 2;
    checkCnt++;
    if (holdErr !== 0) $display("[TB] FAIL rand_hold errors=%0d exp=0", holdErr);
    else passCnt++;
    checkCnt++;
    if (pushed !== 40 || gotQ.size() !== 20)
      $display("[TB] FAIL rand_word_count got=%0d pushed=%0d exp=20", gotQ.size(), pushed);
    else passCnt++;
    for (int k = 0; k < 20 && k < gotQ.size(); k++) begin
      checkCnt++;
      if (gotQ[k] !== {1'b0, b[2*k+1], b[2*k]})
        $display("[TB] FAIL rand_word%0d got=%h exp=%h", k, gotQ[k], {1'b0, b[2*k+1], b[2*k]});
      else passCnt++;
    end
    checkCnt++;
    if (words_sent !== 16'(expSent)) $display("[TB] FAIL rand_words_sent got=%0d exp=%0d", words_sent, expSent);
    else passCnt++;
  endtask

  task automatic test_empty;
    int readBase = readCnt;
    for (int i = 0; i < 20; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      flush = 1'($urandom_range(0, 1));
      tick(1);
    end
    flush = 1'b0;
    checkCnt++;
    if (readCnt - readBase !== 0 || out_valid !== 1'b0)
      $display("[TB] FAIL empty_no_read reads=%0d valid=%b exp reads=0 valid=0", readCnt - readBase, out_valid);
    else passCnt++;
    checkCnt++;
    if (emptyReadViol !== 0) $display("[TB] FAIL read_on_empty got=%0d exp=0", emptyReadViol);
    else passCnt++;
  endtask

  task automatic test_reset_mid;
    logic [7:0] c0, c1;
    out_ready = 1'b0;
    pushByte(8'($urandom)); pushByte(8'($urandom)); pushByte(8'($urandom));
    tick(8);
    checkCnt++;
    if (out_valid !== 1'b1 || words_sent === 16'h0000)
      $display("[TB] FAIL rstmid_setup valid=%b words=%0d exp valid=1 words>0", out_valid, words_sent);
    else passCnt++;
    rst_ = 1'b0;
    #1;
    checkCnt++;
    if (out_valid !== 1'b0 || words_sent !== 16'h0000 || fifo_read !== 1'b0)
      $display("[TB] FAIL rstmid_async valid=%b words=%0d read=%b exp 0 0 0", out_valid, words_sent, fifo_read);
    else passCnt++;
    tick(2);
    rst_ = 1'b1;
    expSent = 0;
    gotQ.delete();
    out_ready = 1'b1;
    c0 = 8'($urandom);
    c1 = 8'($urandom);
    pushByte(c0);
    pushByte(c1);
    tick(8);
    expSent += 1;
    checkCnt++;
    if (gotQ.size() !== 1 || gotQ[0] !== {1'b0, c1, c0})
      $display("[TB] FAIL rstmid_clean got=%h count=%0d exp=%h", (gotQ.size() > 0) ? gotQ[0] : 17'h0, gotQ.size(), {1'b0, c1, c0});
    else passCnt++;
  endtask

  task automatic test_saturate;
    for (int i = 0; i < 4; i++) pushByte(8'($urandom));
    tick(10);
    expSent += 2;
    checkCnt++;
    if (satWords !== 2'b11 || words_sent !== 16'(expSent))
      $display("[TB] FAIL sat_reach sat=%0d main=%0d exp sat=3 main=%0d", satWords, words_sent, expSent);
    else passCnt++;
    pushByte(8'($urandom));
    pushByte(8'($urandom));
    tick(8);
    expSent += 1;
    checkCnt++;
    if (satWords !== 2'b11 || words_sent !== 16'(expSent))
      $display("[TB] FAIL sat_hold sat=%0d main=%0d exp sat=3 main=%0d", satWords, words_sent, expSent);
    else passCnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_random();
    test_empty();
    test_reset_mid();
    test_saturate();
    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL timeout passed=%0d total=%0d", passCnt, checkCnt);
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
